mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle main control FSM for the 32-bit core.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, register file and unified memory port.
- Drives the 4-bit ALU operation code directly, replacing the separate per-cycle ALU decode.
- Paces instruction memory with a ready handshake and resolves all six conditional branches from ALU flags.

Parameters:
- OPW, 6, opcode and funct field width.
- AOPW, 4, ALU operation code width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- insop  in  6  instruction opcode, bits [31:26] of the instruction register (IR).
- insfunc  in  6  R-format funct, IR[5:0].
- alu_zero  in  1  ALU result == 0.
- alu_neg  in  1  ALU result bit 31.
- mem_ready  in  1  memory access completes this cycle.
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR write enable.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- reg_we  out  1  register-file write enable.
- reg_dst  out  1  destination select: 1 = rd, 0 = rt.
- mem_to_reg  out  1  writeback source: 1 = memory data register, 0 = ALUOut.
- alu_src_a  out  1  ALU operand A: 0 = PC, 1 = regA.
- alu_src_b  out  3  ALU operand B: 0 = regB, 1 = const 4, 2 = sign-extended imm, 3 = zero-extended imm, 4 = sign-extended imm << 2.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- alu_op  out  4  ALU operation code.
- illegal  out  1  unsupported instruction flag.

Behaviour:
- Opcodes: rfmt=0, beq=3, bne=4, addi=10, andi=14, ori=15, xori=16, blt=30, bgt=31, bge=32, ble=33, lw=43, sw=53.
- R-format funct codes: sll=0, srl=2, add=40, addu=41, sub=42, subu=43, and=44, or=45, xor=46, nor=47.
- alu_op encoding: add 0, sub 1, and 2, or 3, xor 4, nor 5, srl 6, sll 7, addu 8, subu 9.
- Reset: async to IDLE. Every output is 0 while in IDLE. IDLE moves to FETCH on the next clock.
- FETCH:
  - Outputs: mem_rd=1, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0.
  - Hold in FETCH while mem_ready=0; pc_we and ir_we stay 0.
  - On the cycle mem_ready=1: pc_we=1, ir_we=1, next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=4, alu_op=0 (branch target into ALUOut). Dispatch on insop:
  - rfmt -> EXEC_R.
  - addi, andi, ori, xori -> EXEC_I.
  - lw, sw -> MEM_ADDR.
  - beq, bne, blt, bgt, bge, ble -> BRANCH.
  - any other opcode -> ILLEGAL handling.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op from funct. Unknown funct -> ILLEGAL handling. Next state WB_R.
- WB_R: reg_we=1, reg_dst=1, mem_to_reg=0, alu_op held. Next state FETCH.
- EXEC_I: alu_src_a=1.
  - addi: alu_src_b=2, alu_op=0.
  - andi, ori, xori: alu_src_b=3, alu_op=2, 3, 4 respectively.
  - Next state WB_I.
- WB_I: reg_we=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_rd=1; hold until mem_ready=1, then WB_MEM.
- MEM_WR: mem_wr=1; hold until mem_ready=1, then FETCH.
- WB_MEM: reg_we=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1 (regA - regB), pc_src=1.
  - pc_we = taken: beq zero; bne !zero; blt neg; bgt !neg & !zero; bge !neg; ble neg | zero.
  - Next state FETCH.
- Cycle counts with mem_ready tied 1: branch 3; R, I and sw 4; lw 5. Each mem_ready=0 cycle adds exactly one cycle.
- pc_we, ir_we, mem_rd, mem_wr and reg_we are never asserted in the same cycle as mem_wr together with reg_we.
- Reset asserted mid-instruction aborts it. No write enable is asserted in the reset cycle or in the IDLE cycle.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: ILLEGAL handling enters TRAP.
  - TRAP asserts illegal=1; all enables stay 0.
  - TRAP is left only by rst.
- Not defined: ILLEGAL handling returns to FETCH as a NOP (no writes); illegal is tied to 0.

Test Plan:
- rst pulse, mem_ready=1, insop=0, insfunc=42 -> IDLE 1 cycle with all outputs 0; FETCH pc_we=ir_we=1; EXEC_R alu_op=1; WB_R reg_we=1, reg_dst=1; back to FETCH on cycle 4.
- insop=43, mem_ready low for 2 cycles in MEM_RD -> mem_rd held 3 cycles; WB_MEM reg_we=1, mem_to_reg=1; 7 cycles total.
- insop=31 (bgt): zero=0, neg=0 -> BRANCH pc_we=1, pc_src=1. Then zero=1 -> pc_we=0.
- insop=14 (andi) -> EXEC_I alu_src_b=3, alu_op=2; WB_I reg_we=1, reg_dst=0.
- insop=53 (sw) -> MEM_WR mem_wr=1, reg_we never 1; 4 cycles.
- insop=63 with ILLEGAL_TRAP_EN -> illegal=1 and stays 1 for 10+ cycles until rst. Without the macro -> FETCH follows DECODE, no write enables asserted.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle main control FSM: fetch/decode/execute/memory/writeback sequencing, ALU op drive, branch resolve.
// Latency: branch 3, R/I/sw 4, lw 5 cycles; each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds one.
// Backpressure: memory stalls via mem_ready. ILLEGAL_TRAP_EN defined -> illegal ops park in TRAP until rst.
module mc_ctrl #(
    parameter int OPW  = 6,
    parameter int AOPW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  insop,
    input  logic [OPW-1:0]  insfunc,
    input  logic            alu_zero,
    input  logic            alu_neg,
    input  logic            mem_ready,
    output logic            pc_we,
    output logic            ir_we,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            reg_we,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            alu_src_a,
    output logic [2:0]      alu_src_b,
    output logic            pc_src,
    output logic [AOPW-1:0] alu_op,
    output logic            illegal
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_WB_R     = 4'd4;
    localparam logic [3:0] S_EXEC_I   = 4'd5;
    localparam logic [3:0] S_WB_I     = 4'd6;
    localparam logic [3:0] S_MEM_ADDR = 4'd7;
    localparam logic [3:0] S_MEM_RD   = 4'd8;
    localparam logic [3:0] S_MEM_WR   = 4'd9;
    localparam logic [3:0] S_WB_MEM   = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

`ifdef ILLEGAL_TRAP_EN
    localparam logic [3:0] S_ILL_NEXT = S_TRAP;
`else
    localparam logic [3:0] S_ILL_NEXT = S_FETCH;
`endif

    localparam logic [OPW-1:0] OP_RFMT = 6'd0;
    localparam logic [OPW-1:0] OP_BEQ  = 6'd3;
    localparam logic [OPW-1:0] OP_BNE  = 6'd4;
    localparam logic [OPW-1:0] OP_ADDI = 6'd10;
    localparam logic [OPW-1:0] OP_ANDI = 6'd14;
    localparam logic [OPW-1:0] OP_ORI  = 6'd15;
    localparam logic [OPW-1:0] OP_XORI = 6'd16;
    localparam logic [OPW-1:0] OP_BLT  = 6'd30;
    localparam logic [OPW-1:0] OP_BGT  = 6'd31;
    localparam logic [OPW-1:0] OP_BGE  = 6'd32;
    localparam logic [OPW-1:0] OP_BLE  = 6'd33;
    localparam logic [OPW-1:0] OP_LW   = 6'd43;
    localparam logic [OPW-1:0] OP_SW   = 6'd53;

    localparam logic [OPW-1:0] FN_SLL  = 6'd0;
    localparam logic [OPW-1:0] FN_SRL  = 6'd2;
    localparam logic [OPW-1:0] FN_ADD  = 6'd40;
    localparam logic [OPW-1:0] FN_ADDU = 6'd41;
    localparam logic [OPW-1:0] FN_SUB  = 6'd42;
    localparam logic [OPW-1:0] FN_SUBU = 6'd43;
    localparam logic [OPW-1:0] FN_AND  = 6'd44;
    localparam logic [OPW-1:0] FN_OR   = 6'd45;
    localparam logic [OPW-1:0] FN_XOR  = 6'd46;
    localparam logic [OPW-1:0] FN_NOR  = 6'd47;

    localparam logic [AOPW-1:0] ALU_ADD  = 4'd0;
    localparam logic [AOPW-1:0] ALU_SUB  = 4'd1;
    localparam logic [AOPW-1:0] ALU_AND  = 4'd2;
    localparam logic [AOPW-1:0] ALU_OR   = 4'd3;
    localparam logic [AOPW-1:0] ALU_XOR  = 4'd4;
    localparam logic [AOPW-1:0] ALU_NOR  = 4'd5;
    localparam logic [AOPW-1:0] ALU_SRL  = 4'd6;
    localparam logic [AOPW-1:0] ALU_SLL  = 4'd7;
    localparam logic [AOPW-1:0] ALU_ADDU = 4'd8;
    localparam logic [AOPW-1:0] ALU_SUBU = 4'd9;

    localparam logic [2:0] SB_REGB  = 3'd0;
    localparam logic [2:0] SB_FOUR  = 3'd1;
    localparam logic [2:0] SB_SEXT  = 3'd2;
    localparam logic [2:0] SB_ZEXT  = 3'd3;
    localparam logic [2:0] SB_SEXT2 = 3'd4;

    logic [3:0]      state_q, state_d;
    logic [AOPW-1:0] r_aop;
    logic            r_ok;
    logic            br_taken;

    // IR is stable from DECODE onward, so WB_R re-decodes funct to hold alu_op
    always_comb begin
        r_ok  = 1'b1;
        r_aop = ALU_ADD;
        case (insfunc)
            FN_SLL:  r_aop = ALU_SLL;
            FN_SRL:  r_aop = ALU_SRL;
            FN_ADD:  r_aop = ALU_ADD;
            FN_ADDU: r_aop = ALU_ADDU;
            FN_SUB:  r_aop = ALU_SUB;
            FN_SUBU: r_aop = ALU_SUBU;
            FN_AND:  r_aop = ALU_AND;
            FN_OR:   r_aop = ALU_OR;
            FN_XOR:  r_aop = ALU_XOR;
            FN_NOR:  r_aop = ALU_NOR;
            default: r_ok  = 1'b0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (insop)
            OP_BEQ:  br_taken = alu_zero;
            OP_BNE:  br_taken = !alu_zero;
            OP_BLT:  br_taken = alu_neg;
            OP_BGT:  br_taken = !alu_neg && !alu_zero;
            OP_BGE:  br_taken = !alu_neg;
            OP_BLE:  br_taken = alu_neg || alu_zero;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SB_REGB;
        pc_src     = 1'b0;
        alu_op     = ALU_ADD;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = SB_FOUR;
                if (mem_ready) begin
                    pc_we   = 1'b1;
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SB_SEXT2;
                case (insop)
                    OP_RFMT:                         state_d = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:                    state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE, OP_BLT,
                    OP_BGT, OP_BGE, OP_BLE:          state_d = S_BRANCH;
                    default:                         state_d = S_ILL_NEXT;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = r_aop;
                state_d   = r_ok ? S_WB_R : S_ILL_NEXT;
            end
            S_WB_R: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
                alu_op  = r_aop;
                state_d = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                case (insop)
                    OP_ANDI: begin alu_src_b = SB_ZEXT; alu_op = ALU_AND; end
                    OP_ORI:  begin alu_src_b = SB_ZEXT; alu_op = ALU_OR;  end
                    OP_XORI: begin alu_src_b = SB_ZEXT; alu_op = ALU_XOR; end
                    default: begin alu_src_b = SB_SEXT; alu_op = ALU_ADD; end
                endcase
                state_d = S_WB_I;
            end
            S_WB_I: begin
                reg_we  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SB_SEXT;
                state_d   = (insop == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_rd = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_wr = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_WB_MEM: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 1'b1;
                pc_we     = br_taken;
                state_d   = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state_q == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle comparison of the full output vector against hand-built values.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] insop, insfunc;
    logic       alu_zero, alu_neg, mem_ready;
    logic       pc_we, ir_we, mem_rd, mem_wr, reg_we, reg_dst, mem_to_reg, alu_src_a, pc_src, illegal;
    logic [2:0] alu_src_b;
    logic [3:0] alu_op;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.OPW(6), .AOPW(4)) dut (
        .clk(clk), .rst(rst), .insop(insop), .insfunc(insfunc),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .mem_ready(mem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_op(alu_op), .illegal(illegal)
    );

    // {pc_we,ir_we,mem_rd,mem_wr,reg_we,reg_dst,mem_to_reg,alu_src_a,alu_src_b[2:0],pc_src,alu_op[3:0],illegal}
    function automatic logic [16:0] ov(input logic pcw, input logic irw, input logic mrd, input logic mwr,
                                       input logic rwe, input logic rdst, input logic m2r, input logic sa,
                                       input logic [2:0] sb, input logic ps, input logic [3:0] ao,
                                       input logic ill);
        return {pcw, irw, mrd, mwr, rwe, rdst, m2r, sa, sb, ps, ao, ill};
    endfunction

    function automatic logic [16:0] obs();
        return {pc_we, ir_we, mem_rd, mem_wr, reg_we, reg_dst, mem_to_reg, alu_src_a,
                alu_src_b, pc_src, alu_op, illegal};
    endfunction

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got=%05h expected=%05h", tag, got, exp);
        end
    endtask

    // Called at a negedge with inputs already set; samples then advances one cycle.
    task automatic cyc(input string tag, input logic [16:0] exp);
        #1;
        chk(tag, obs(), exp);
        @(negedge clk);
    endtask

    task automatic do_fetch();
        mem_ready = 1'b1;
        cyc("fetch", ov(1,1,1,0,0,0,0,0,3'd1,0,4'd0,0));
    endtask

    task automatic do_decode();
        cyc("decode", ov(0,0,0,0,0,0,0,0,3'd4,0,4'd0,0));
    endtask

    task automatic run_r(input logic [5:0] fn, input logic [3:0] aop);
        insop = 6'd0; insfunc = fn;
        do_fetch();
        do_decode();
        cyc($sformatf("exec_r f%0d", fn), ov(0,0,0,0,0,0,0,1,3'd0,0,aop,0));
        cyc($sformatf("wb_r f%0d", fn),   ov(0,0,0,0,1,1,0,0,3'd0,0,aop,0));
    endtask

    task automatic run_i(input logic [5:0] op, input logic [2:0] sb, input logic [3:0] aop);
        insop = op;
        do_fetch();
        do_decode();
        cyc($sformatf("exec_i op%0d", op), ov(0,0,0,0,0,0,0,1,sb,0,aop,0));
        cyc($sformatf("wb_i op%0d", op),   ov(0,0,0,0,1,0,0,0,3'd0,0,4'd0,0));
    endtask

    task automatic run_br(input logic [5:0] op, input logic z, input logic n, input logic taken);
        insop = op;
        do_fetch();
        do_decode();
        alu_zero = z; alu_neg = n;
        cyc($sformatf("branch op%0d z%0d n%0d", op, z, n), ov(taken,0,0,0,0,0,0,1,3'd0,1,4'd1,0));
    endtask

    localparam logic [16:0] ZERO = 17'd0;

    initial begin
        logic [5:0] r_fn [10];
        logic [3:0] r_ao [10];
        logic [5:0] i_op [4];
        logic [2:0] i_sb [4];
        logic [3:0] i_ao [4];
        r_fn = '{6'd0, 6'd2, 6'd40, 6'd41, 6'd42, 6'd43, 6'd44, 6'd45, 6'd46, 6'd47};
        r_ao = '{4'd7, 4'd6, 4'd0,  4'd8,  4'd1,  4'd9,  4'd2,  4'd3,  4'd4,  4'd5};
        i_op = '{6'd10, 6'd14, 6'd15, 6'd16};
        i_sb = '{3'd2,  3'd3,  3'd3,  3'd3};
        i_ao = '{4'd0,  4'd2,  4'd3,  4'd4};

        rst = 1'b1; insop = 6'd0; insfunc = 6'd42;
        alu_zero = 1'b0; alu_neg = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        cyc("in_reset", ZERO);
        rst = 1'b0;
        cyc("idle", ZERO);

        // sub: FETCH, DECODE, EXEC_R, WB_R, then FETCH on cycle 4 (next task's fetch check)
        run_r(6'd42, 4'd1);
        for (int i = 0; i < 10; i++) run_r(r_fn[i], r_ao[i]);

        // lw with FETCH stall and two MEM_RD stall cycles
        insop = 6'd43;
        mem_ready = 1'b0;
        cyc("fetch_stall", ov(0,0,1,0,0,0,0,0,3'd1,0,4'd0,0));
        do_fetch();
        do_decode();
        cyc("lw_addr", ov(0,0,0,0,0,0,0,1,3'd2,0,4'd0,0));
        mem_ready = 1'b0;
        cyc("lw_rd_stall0", ov(0,0,1,0,0,0,0,0,3'd0,0,4'd0,0));
        cyc("lw_rd_stall1", ov(0,0,1,0,0,0,0,0,3'd0,0,4'd0,0));
        mem_ready = 1'b1;
        cyc("lw_rd_done", ov(0,0,1,0,0,0,0,0,3'd0,0,4'd0,0));
        cyc("lw_wb", ov(0,0,0,0,1,0,1,0,3'd0,0,4'd0,0));

        // sw with one MEM_WR stall
        insop = 6'd53;
        do_fetch();
        do_decode();
        cyc("sw_addr", ov(0,0,0,0,0,0,0,1,3'd2,0,4'd0,0));
        mem_ready = 1'b0;
        cyc("sw_wr_stall", ov(0,0,0,1,0,0,0,0,3'd0,0,4'd0,0));
        mem_ready = 1'b1;
        cyc("sw_wr_done", ov(0,0,0,1,0,0,0,0,3'd0,0,4'd0,0));

        for (int i = 0; i < 4; i++) run_i(i_op[i], i_sb[i], i_ao[i]);

        run_br(6'd31, 1'b0, 1'b0, 1'b1);
        run_br(6'd31, 1'b1, 1'b0, 1'b0);
        run_br(6'd31, 1'b0, 1'b1, 1'b0);
        run_br(6'd3,  1'b1, 1'b0, 1'b1);
        run_br(6'd3,  1'b0, 1'b1, 1'b0);
        run_br(6'd4,  1'b1, 1'b0, 1'b0);
        run_br(6'd4,  1'b0, 1'b0, 1'b1);
        run_br(6'd30, 1'b0, 1'b1, 1'b1);
        run_br(6'd30, 1'b0, 1'b0, 1'b0);
        run_br(6'd32, 1'b1, 1'b0, 1'b1);
        run_br(6'd32, 1'b0, 1'b1, 1'b0);
        run_br(6'd33, 1'b1, 1'b0, 1'b1);
        run_br(6'd33, 1'b0, 1'b0, 1'b0);

        // reset mid-instruction (lw in MEM_ADDR) aborts and restarts through IDLE
        insop = 6'd43;
        do_fetch();
        do_decode();
        rst = 1'b1;
        cyc("abort", ZERO);
        rst = 1'b0;
        cyc("abort_idle", ZERO);

`ifdef ILLEGAL_TRAP_EN
        insop = 6'd63;
        do_fetch();
        do_decode();
        for (int i = 0; i < 12; i++) cyc($sformatf("trap%0d", i), ov(0,0,0,0,0,0,0,0,3'd0,0,4'd0,1));
        rst = 1'b1;
        cyc("trap_rst", ZERO);
        rst = 1'b0;
        cyc("trap_idle", ZERO);
        do_fetch();
`else
        insop = 6'd63;
        do_fetch();
        do_decode();
        do_fetch();
        do_decode();
        // unknown funct: no enables in EXEC_R, then straight back to FETCH
        insop = 6'd0; insfunc = 6'd1;
        do_fetch();
        do_decode();
        #1;
        chk("badfunct_en", obs() & 17'h1F001, ZERO);
        @(negedge clk);
        do_fetch();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
